dram_port_arbiter: RTL and testbench

- Shares one single-port, PE_ELEMENTS-wide data RAM bank between two requesters.
  - Requester 0: PE fetch/store path.
  - Requester 1: host loader, which preloads operands and drains results.
- Sits between the PE fetch unit's RAM-facing ports and the RAM macro.
- Grants at most one access per cycle and returns read data with fixed 1-cycle latency to the winner.
- Policy: PE priority while a program runs, round-robin otherwise, with optional host burst lock.

---
 rtl/simd_pkg.sv | 9 +
 rtl/rd_return_tracker.sv | 48 ++++
 rtl/dram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_dram_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the data RAM port arbiter: owner states, requester ids and the RAM word layout.
package simd_pkg;
  localparam int VEC_DATA_LEN = 32;
  localparam int VEC_ELEMENTS = 4;

  typedef enum logic [1:0] {IDLE, PE_OWN, HOST_OWN} arb_state_t;
  typedef enum logic {REQ_PE, REQ_HOST} req_id_t;
  typedef logic [VEC_ELEMENTS-1:0][VEC_DATA_LEN-1:0] vec_t;
endpackage

// File: rtl/rd_return_tracker.sv
// Remembers which requester owns the read issued last cycle and steers RAM read data back to it.
// Each requester's rdata holds its last returned word until that requester's next rvalid.
module rd_return_tracker
  import simd_pkg::*;
#(
  parameter int W = VEC_ELEMENTS * VEC_DATA_LEN
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         rd_gnt,
  input  req_id_t      rd_id,
  input  logic [W-1:0] ram_rdata,
  output logic         pe_rvalid,
  output logic [W-1:0] pe_rdata,
  output logic         host_rvalid,
  output logic [W-1:0] host_rdata
);
  logic         rd_vld_q, rd_vld_d;
  req_id_t      rd_id_q, rd_id_d;
  logic [W-1:0] pe_hold_q, pe_hold_d;
  logic [W-1:0] host_hold_q, host_hold_d;

  always_comb begin
    rd_vld_d    = rd_gnt;
    rd_id_d     = rd_id;
    // Reset asserted while a read is in flight must suppress its return.
    pe_rvalid   = rstn && rd_vld_q && (rd_id_q == REQ_PE);
    host_rvalid = rstn && rd_vld_q && (rd_id_q == REQ_HOST);
    pe_hold_d   = pe_rvalid ? ram_rdata : pe_hold_q;
    host_hold_d = host_rvalid ? ram_rdata : host_hold_q;
    pe_rdata    = pe_hold_d;
    host_rdata  = host_hold_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_vld_q    <= 1'b0;
      rd_id_q     <= REQ_PE;
      pe_hold_q   <= '0;
      host_hold_q <= '0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      rd_id_q     <= rd_id_d;
      pe_hold_q   <= pe_hold_d;
      host_hold_q <= host_hold_d;
    end
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one single-port data RAM between the PE path and the host loader; grants are same-cycle, reads return 1 cycle later.
// Optional host starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module dram_port_arbiter
  import simd_pkg::*;
#(
  parameter int DATA_LEN     = VEC_DATA_LEN,
  parameter int PE_ELEMENTS  = VEC_ELEMENTS,
  parameter int DRAM_DEPTH   = 256,
  parameter int STARVE_LIMIT = 8,
  localparam int ADDR_W      = $clog2(DRAM_DEPTH),
  localparam int W           = PE_ELEMENTS * DATA_LEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pe_busy,
  input  logic              pe_req,
  input  logic              pe_we,
  input  logic [ADDR_W-1:0] pe_addr,
  input  logic [W-1:0]      pe_wdata,
  output logic              pe_gnt,
  output logic              pe_rvalid,
  output logic [W-1:0]      pe_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [W-1:0]      host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [W-1:0]      host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [W-1:0]      ram_wdata,
  input  logic [W-1:0]      ram_rdata,
  output logic [15:0]       conflict_cnt
);
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_t state_q, state_d;
  req_id_t    rr_ptr_q, rr_ptr_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic       pe_win, host_win;
  logic       starve_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = host_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = (host_req && !host_gnt) ? starve_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    pe_win   = 1'b0;
    host_win = 1'b0;
    if (starve_force) begin
      host_win = 1'b1;
    end else if (pe_busy) begin
      pe_win   = pe_req;
      host_win = host_req && !pe_req;
    end else if (state_q == HOST_OWN && host_lock && host_req) begin
      host_win = 1'b1;
    end else if (pe_req && host_req) begin
      // rr_ptr names the last contended winner; the other side goes next.
      pe_win   = (rr_ptr_q == REQ_HOST);
      host_win = (rr_ptr_q == REQ_PE);
    end else begin
      pe_win   = pe_req;
      host_win = host_req;
    end
    pe_gnt   = rstn && pe_win;
    host_gnt = rstn && host_win;

    state_d = pe_gnt ? PE_OWN : (host_gnt ? HOST_OWN : IDLE);

    rr_ptr_d = rr_ptr_q;
    if (!pe_busy && pe_req && host_req) rr_ptr_d = host_gnt ? REQ_HOST : REQ_PE;

    conflict_cnt_d = conflict_cnt_q;
    if (pe_req && host_req && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;

    ram_en    = pe_gnt || host_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (pe_gnt) begin
      ram_we    = pe_we;
      ram_addr  = pe_addr;
      ram_wdata = pe_wdata;
    end else if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      rr_ptr_q       <= REQ_PE;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

  rd_return_tracker #(.W(W)) u_rd_return_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .rd_gnt     (ram_en && !ram_we),
    .rd_id      (host_gnt ? REQ_HOST : REQ_PE),
    .ram_rdata  (ram_rdata),
    .pe_rvalid  (pe_rvalid),
    .pe_rdata   (pe_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata)
  );
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios then random traffic against a behavioural arbitration/RAM model.
module tb_dram_port_arbiter;
  localparam int W  = 128;
  localparam int AW = 8;
  localparam int STARVE_LIMIT = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pe_busy = 1'b0, pe_req = 1'b0, pe_we = 1'b0;
  logic [AW-1:0] pe_addr = '0;
  logic [W-1:0]  pe_wdata = '0;
  logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [W-1:0]  host_wdata = '0;
  logic          pe_gnt, pe_rvalid, host_gnt, host_rvalid, ram_en, ram_we;
  logic [W-1:0]  pe_rdata, host_rdata, ram_wdata;
  logic [W-1:0]  ram_rdata = '0;
  logic [AW-1:0] ram_addr;
  logic [15:0]   conflict_cnt;

  logic [W-1:0]  ram_mem [256];
  logic [W-1:0]  ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last owner (0 none, 1 PE, 2 host), last contended winner, pending read owner.
  int           m_owner, m_rr, m_conf, m_starve, m_rd;
  logic [W-1:0] m_rd_word, m_pe_hold, m_host_hold;
  bit           p_pend, h_pend;

  always #5 clk = ~clk;

  dram_port_arbiter dut (
    .clk(clk), .rstn(rstn), .pe_busy(pe_busy),
    .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr), .pe_wdata(pe_wdata),
    .pe_gnt(pe_gnt), .pe_rvalid(pe_rvalid), .pe_rdata(pe_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  // Single-port RAM macro with one cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  function automatic logic [W-1:0] init_word(int i);
    return {4{32'hA500_0000 | i}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner();
    if (!rstn) return 0;
`ifdef ARB_STARVE_GUARD_EN
    if (host_req && m_starve == STARVE_LIMIT) return 2;
`endif
    if (pe_busy) return pe_req ? 1 : (host_req ? 2 : 0);
    if (m_owner == 2 && host_lock && host_req) return 2;
    if (pe_req && host_req) return (m_rr == 0) ? 2 : 1;
    return pe_req ? 1 : (host_req ? 2 : 0);
  endfunction

  task automatic model_reset();
    m_owner = 0; m_rr = 0; m_conf = 0; m_starve = 0; m_rd = 0;
    m_rd_word = '0; m_pe_hold = '0; m_host_hold = '0;
  endtask

  // Called one time unit after a rising edge with inputs already applied; checks mid-cycle, then advances the model.
  task automatic run_cycle(input string tag);
    int w;
    logic [W-1:0] e_addr, e_wdata;
    logic e_we;
    #3;
    w = exp_winner();
    e_addr  = (w == 1) ? W'(pe_addr)  : (w == 2) ? W'(host_addr)  : '0;
    e_wdata = (w == 1) ? pe_wdata     : (w == 2) ? host_wdata     : '0;
    e_we    = (w == 1) ? pe_we        : (w == 2) ? host_we        : 1'b0;
    chk({tag, ".pe_gnt"},    W'(pe_gnt),   W'(w == 1));
    chk({tag, ".host_gnt"},  W'(host_gnt), W'(w == 2));
    chk({tag, ".ram_en"},    W'(ram_en),   W'(w != 0));
    chk({tag, ".ram_we"},    W'(ram_we),   W'(e_we));
    chk({tag, ".ram_addr"},  W'(ram_addr), e_addr);
    chk({tag, ".ram_wdata"}, ram_wdata,    e_wdata);
    chk({tag, ".pe_rvalid"},   W'(pe_rvalid),   W'(rstn && m_rd == 1));
    chk({tag, ".host_rvalid"}, W'(host_rvalid), W'(rstn && m_rd == 2));
    chk({tag, ".pe_rdata"},   pe_rdata,   (rstn && m_rd == 1) ? m_rd_word : m_pe_hold);
    chk({tag, ".host_rdata"}, host_rdata, (rstn && m_rd == 2) ? m_rd_word : m_host_hold);
    chk({tag, ".conflict_cnt"}, W'(conflict_cnt), W'(m_conf));
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else begin
      if (m_rd == 1) m_pe_hold = m_rd_word;
      if (m_rd == 2) m_host_hold = m_rd_word;
      m_rd = 0;
      if (w != 0) begin
        if (e_we) ref_mem[e_addr[AW-1:0]] = e_wdata;
        else begin
          m_rd = w;
          m_rd_word = ref_mem[e_addr[AW-1:0]];
        end
      end
      if (pe_req && host_req && m_conf < 16'hFFFF) m_conf++;
      if (!pe_busy && pe_req && host_req) m_rr = (w == 2) ? 1 : 0;
      m_starve = (host_req && w != 2) ? m_starve + 1 : 0;
      m_owner = w;
    end
    p_pend = pe_req && (w != 1);
    h_pend = host_req && (w != 2);
  endtask

  task automatic set_pe(input bit req, input bit we, input int addr, input logic [W-1:0] wd);
    pe_req = req; pe_we = we; pe_addr = AW'(addr); pe_wdata = wd;
  endtask

  task automatic set_host(input bit req, input bit we, input int addr, input logic [W-1:0] wd);
    host_req = req; host_we = we; host_addr = AW'(addr); host_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    @(posedge clk);
    #1;

    // Reset with both requesters active.
    rstn = 1'b0;
    set_pe(1, 0, 7, '0);
    set_host(1, 0, 9, '0);
    run_cycle("reset0");
    run_cycle("reset1");

    // First cycle out of reset: PE-only request at address 5.
    rstn = 1'b1;
    set_host(0, 0, 0, '0);
    set_pe(1, 0, 5, '0);
    run_cycle("pe_rd5");
    set_pe(0, 0, 0, '0);
    run_cycle("pe_rd5_ret");

    // Host write then read back of address 3.
    set_host(1, 1, 3, W'(32'h11));
    run_cycle("host_wr3");
    set_host(1, 0, 3, '0);
    run_cycle("host_rd3");
    set_host(0, 0, 0, '0);
    run_cycle("host_rd3_ret");

    // Round-robin from a fresh reset.
    rstn = 1'b0;
    run_cycle("rr_reset");
    rstn = 1'b1;
    set_pe(1, 0, 10, '0);
    set_host(1, 0, 20, '0);
    for (int i = 0; i < 4; i++) run_cycle($sformatf("rr%0d", i));
    set_pe(0, 0, 0, '0);
    set_host(0, 0, 0, '0);
    run_cycle("rr_done");

    // PE priority while a program runs.
    rstn = 1'b0;
    run_cycle("busy_reset");
    rstn = 1'b1;
    pe_busy = 1'b1;
    set_pe(1, 1, 30, {4{32'hC0DE_0001}});
    set_host(1, 0, 40, '0);
    for (int i = 0; i < 20; i++) run_cycle($sformatf("busy%0d", i + 1));
    pe_busy = 1'b0;
    set_pe(0, 0, 0, '0);
    set_host(0, 0, 0, '0);
    run_cycle("busy_done");

    // Host burst lock, then pe_busy preempts it.
    rstn = 1'b0;
    run_cycle("lock_reset");
    rstn = 1'b1;
    set_pe(1, 0, 50, '0);
    set_host(1, 0, 3, '0);
    host_lock = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle($sformatf("lock%0d", i + 1));
    pe_busy = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle($sformatf("lock_busy%0d", i + 1));
    pe_busy = 1'b0;
    host_lock = 1'b0;
    set_pe(0, 0, 0, '0);
    set_host(0, 0, 0, '0);
    run_cycle("lock_done");

    // Reset right behind a host read: the return is dropped.
    set_host(1, 0, 3, '0);
    run_cycle("inflight_rd");
    set_host(0, 0, 0, '0);
    rstn = 1'b0;
    run_cycle("inflight_reset");
    rstn = 1'b1;
    run_cycle("inflight_after");

    // Random traffic; request fields stay put until granted.
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) pe_busy = ~pe_busy;
      host_lock = ($urandom_range(0, 2) != 0);
      if (!p_pend)
        set_pe($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
               {$urandom, $urandom, $urandom, $urandom});
      if (!h_pend)
        set_host($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                 {$urandom, $urandom, $urandom, $urandom});
      run_cycle($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
